// File: rtl/hk_wb_arbiter.sv
// Two-master Wishbone arbiter for the housekeeping register slave.
// Round-robin grant held for a whole bus cycle, with a stuck-slave timeout that returns err to the owner.
module hk_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        wb_clk_i,
  input  logic        porb,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,

  output logic [1:0]  grant_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic             last_owner, last_owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             err_q, err_nxt;

  logic             req0, req1, pick;
  logic             own_cyc, own_stb, own_we;
  logic [3:0]       own_sel;
  logic [31:0]      own_adr, own_dat;
  logic             in_own, stall, fwd_ack;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // On a tie the master that did not own last time wins; otherwise the lone requester.
  assign pick = (req0 & req1) ? ~last_owner : req1;

  always_comb begin
    if (owner) begin
      own_cyc = m1_cyc_i;
      own_stb = m1_stb_i;
      own_we  = m1_we_i;
      own_sel = m1_sel_i;
      own_adr = m1_adr_i;
      own_dat = m1_dat_i;
    end else begin
      own_cyc = m0_cyc_i;
      own_stb = m0_stb_i;
      own_we  = m0_we_i;
      own_sel = m0_sel_i;
      own_adr = m0_adr_i;
      own_dat = m0_dat_i;
    end
  end

  assign in_own  = (state == OWN);
  assign stall   = in_own & own_stb & ~s_ack_i;
  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    cnt_nxt        = '0;
    err_nxt        = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          owner_nxt      = pick;
          last_owner_nxt = pick;
          state_nxt      = OWN;
        end
      end
      OWN: begin
        // Dropping cyc takes priority over a timeout landing on the same edge.
        if (!own_cyc) begin
          state_nxt = IDLE;
        end else if (stall) begin
          if (cnt_inc == TERM_CNT) begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      ERR: begin
        if (!own_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge porb) begin
    if (!porb) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      cnt        <= cnt_nxt;
      err_q      <= err_nxt;
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (in_own) begin
      s_cyc_o = own_cyc;
      s_stb_o = own_stb;
      s_we_o  = own_we;
      s_sel_o = own_sel;
      s_adr_o = own_adr;
      s_dat_o = own_dat;
    end
  end

  // Return path depends only on registered owner/state, never on the other master's inputs.
  assign fwd_ack  = in_own & s_ack_i;

  assign m0_ack_o = fwd_ack & ~owner;
  assign m1_ack_o = fwd_ack &  owner;
  assign m0_err_o = err_q & ~owner;
  assign m1_err_o = err_q &  owner;
  assign m0_dat_o = (in_own & ~owner) ? s_dat_i : '0;
  assign m1_dat_o = (in_own &  owner) ? s_dat_i : '0;

  assign busy_o   = (state != IDLE);
  assign grant_o  = busy_o ? {owner, ~owner} : 2'b00;

endmodule

// File: doc/hk_wb_arbiter.md
Name: hk_wb_arbiter

Overview:
- Two-master Wishbone arbiter in front of the housekeeping register slave (system-control block: clock-output and IRQ-source registers).
- Master 0 is the management CPU bus. Master 1 is the debug/SPI-side bridge.
- Round-robin grant, held for the whole bus cycle.
- A stuck-slave timeout returns an error to the owner so neither master can hang the shared register bus.

Parameters:
- TIMEOUT_CYCLES, 255: cycles with s_stb_o high and no s_ack_i before an error is returned (range 2..65535).
- CNT_W, 16: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- wb_clk_i  in  1  bus clock
- porb  in  1  reset, asynchronous, active-low
- mN_cyc_i  in  1  master N cycle (N = 0, 1)
- mN_stb_i  in  1  master N strobe
- mN_we_i  in  1  master N write enable
- mN_sel_i  in  4  master N byte selects
- mN_adr_i  in  32  master N address
- mN_dat_i  in  32  master N write data
- mN_ack_o  out  1  master N acknowledge
- mN_err_o  out  1  master N timeout error
- mN_dat_o  out  32  master N read data
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_sel_o  out  4  slave byte selects
- s_adr_o  out  32  slave address
- s_dat_o  out  32  slave write data
- s_ack_i  in  1  slave acknowledge
- s_dat_i  in  32  slave read data
- grant_o  out  2  one-hot current owner; 00 = none
- busy_o  out  1  any state other than IDLE

Behaviour:
Reset
- porb low asynchronously forces state IDLE, grant_o = 00, busy_o = 0, counter = 0, last_owner = 1 (master 0 wins the first tie).
- All s_* outputs, mN_ack_o, mN_err_o and mN_dat_o are 0 during and after reset.
- Reset asserted mid-transfer aborts the transfer immediately. No ack or err is issued for it.

Request and arbitration
- A master requests with mN_cyc_i & mN_stb_i. A stb without cyc is ignored.
- State IDLE: requests are sampled at a clock edge.
  - Only one requester: it becomes owner.
  - Both requesting: owner = the master that is not last_owner.
  - last_owner is updated at grant.
  - Next state: OWN.
- Grant latency is exactly one clock: request seen at edge N, grant_o valid and s_cyc_o high after edge N.

State OWN
- s_cyc_o = owner cyc; s_stb_o = owner stb.
- s_we_o, s_sel_o, s_adr_o and s_dat_o are combinationally muxed from the owner.
- s_ack_i and s_dat_i are routed combinationally to the owner's ack and dat outputs. The non-owner sees ack = 0, err = 0, dat = 0.
- Multiple stb/ack beats are allowed within one cyc.
- Owner deasserts cyc: next state IDLE. grant_o returns to 00 and there is at least one idle cycle between ownerships.
- If s_ack_i arrives in the same cycle as the owner drops cyc, the ack is still forwarded.

Timeout
- The counter increments each cycle in OWN with s_stb_o = 1 and s_ack_i = 0.
- The counter clears on s_ack_i, when stb is low, or on leaving OWN.
- When the counter reaches TIMEOUT_CYCLES, registered:
  - owner err_o pulses high for exactly one cycle;
  - next state ERR;
  - s_cyc_o and s_stb_o are forced to 0.
- State ERR holds the grant with s_cyc_o = 0 and ignores s_ack_i; no ack is forwarded. It exits to IDLE when the owner cyc drops.
- If s_ack_i and the terminal count coincide, the ack wins: it is forwarded, no err is raised, and the counter clears.

Other
- The non-owner may hold its request indefinitely without affecting the owner. It is granted at the next IDLE.
- No combinational path exists from any mN input to the other master's outputs.

Test Plan:
1. Reset with porb = 0 mid-cycle, then release → all outputs 0, grant_o = 00; first simultaneous request is granted to m0.
2. m0 writes 0x2 to 0x26200004, then reads it back through the housekeeping slave → s_cyc_o rises one clock after the request, m0_ack_o is seen, m0_dat_o = 0x2, m1 outputs stay 0.
3. m0 and m1 request simultaneously three times, each releasing after its ack → grant order m0, m1, m0, with an idle cycle (grant_o = 00) between each.
4. m1 holds cyc for two stb/ack beats (writes to 0x2620000C) while m0 requests → m0 stays waiting until m1 drops cyc, then m0 is granted.
5. Slave stub never acks, TIMEOUT_CYCLES = 8 → m0_err_o is high for one cycle after 8 stalled cycles, s_cyc_o drops, m0_ack_o never asserts, and the arbiter returns to IDLE after m0 drops cyc.
6. Stub acks exactly on the terminal-count cycle → ack forwarded, no err, and the counter clears.
